// File: rtl/stack_ctrl_unit.sv
// Multi-cycle control unit for the stack-machine datapath: sequences micro-steps
// from a 4-bit opcode, tracks stack occupancy and traps faults in a sticky state.
module stack_ctrl_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] d_out,
  output logic              ldpc,
  output logic              ldmem,
  output logic              ldalu,
  output logic              pcsrc,
  output logic              memsrc,
  output logic              alusrcA,
  output logic              alusrcB,
  output logic              memRead,
  output logic              memWrite,
  output logic              push,
  output logic              pop,
  output logic              tos,
  output logic [1:0]        stksrc,
  output logic [2:0]        alu_control,
  output logic [SP_W-1:0]   sp_count,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_DUP  = 4'd10;
  localparam logic [3:0] OP_JNZ  = 4'd11;
  localparam logic [3:0] OP_NOP  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd13;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_UNDER = 2'd1;
  localparam logic [1:0] FC_OVER  = 2'd2;
  localparam logic [1:0] FC_ILL   = 2'd3;

  typedef enum logic [3:0] {
    ST_IF, ST_ID, ST_POP1, ST_POP2, ST_ALU, ST_A_PUSH, ST_M_PUSH, ST_M_POP,
    ST_M_WRITE, ST_TOS, ST_Z_CHECK, ST_JUMP, ST_DUP_TOS, ST_DUP_PUSH, ST_HALT, ST_FAULT
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] fault_code_nxt;
  logic [1:0] need;
  logic       is_binary;
  logic       illegal;
  logic       underflow;
  logic       overflow;
  logic       take_branch;

  // Decode-stage legality checks
  always_comb begin
    is_binary = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                (opcode == OP_OR)  || (opcode == OP_XOR);
    illegal   = (opcode > OP_HALT);
    need      = 2'd0;
    if (is_binary)
      need = 2'd2;
    else if ((opcode == OP_NOT) || (opcode == OP_POP) || (opcode == OP_JZ) ||
             (opcode == OP_JNZ) || (opcode == OP_DUP))
      need = 2'd1;
    underflow   = (sp_count < SP_W'(need));
    overflow    = ((opcode == OP_PUSH) || (opcode == OP_DUP)) && (sp_count == SP_W'(DEPTH));
    take_branch = (opcode == OP_JNZ) ? (d_out != '0) : (d_out == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    fault_code_nxt = fault_code;
    case (state)
      ST_IF: state_nxt = ST_ID;
      ST_ID: begin
        if (illegal) begin
          state_nxt      = ST_FAULT;
          fault_code_nxt = FC_ILL;
        end else if (underflow) begin
          state_nxt      = ST_FAULT;
          fault_code_nxt = FC_UNDER;
        end else if (overflow) begin
          state_nxt      = ST_FAULT;
          fault_code_nxt = FC_OVER;
        end else if (is_binary) begin
          state_nxt = ST_POP1;
        end else begin
          case (opcode)
            OP_NOT:          state_nxt = ST_POP2;
            OP_PUSH:         state_nxt = ST_M_PUSH;
            OP_POP:          state_nxt = ST_M_POP;
            OP_JMP:          state_nxt = ST_JUMP;
            OP_JZ, OP_JNZ:   state_nxt = ST_TOS;
            OP_DUP:          state_nxt = ST_DUP_TOS;
            OP_HALT:         state_nxt = ST_HALT;
            default:         state_nxt = ST_IF;
          endcase
        end
      end
      ST_POP1:     state_nxt = ST_POP2;
      ST_POP2:     state_nxt = ST_ALU;
      ST_ALU:      state_nxt = ST_A_PUSH;
      ST_A_PUSH:   state_nxt = ST_IF;
      ST_M_PUSH:   state_nxt = ST_IF;
      ST_M_POP:    state_nxt = ST_M_WRITE;
      ST_M_WRITE:  state_nxt = ST_IF;
      ST_TOS:      state_nxt = ST_Z_CHECK;
      ST_Z_CHECK:  state_nxt = take_branch ? ST_JUMP : ST_IF;
      ST_JUMP:     state_nxt = ST_IF;
      ST_DUP_TOS:  state_nxt = ST_DUP_PUSH;
      ST_DUP_PUSH: state_nxt = ST_IF;
      ST_HALT:     state_nxt = ST_HALT;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_IF;
    endcase
  end

  // Moore strobe decode; everything is held low while reset is asserted
  always_comb begin
    ldpc        = 1'b0;
    ldmem       = 1'b0;
    ldalu       = 1'b0;
    pcsrc       = 1'b0;
    memsrc      = 1'b0;
    alusrcA     = 1'b0;
    alusrcB     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    stksrc      = 2'd0;
    alu_control = 3'd0;
    halted      = 1'b0;
    fault       = 1'b0;
    if (!rst) begin
      case (state)
        ST_IF: begin
          ldpc    = 1'b1;
          memRead = 1'b1;
          ldmem   = 1'b1;
        end
        ST_POP1, ST_POP2, ST_M_POP: pop = 1'b1;
        ST_ALU: begin
          alusrcA = 1'b1;
          alusrcB = 1'b1;
          ldalu   = 1'b1;
          case (opcode)
            OP_OR:   alu_control = 3'd4;
            OP_XOR:  alu_control = 3'd5;
            default: alu_control = {1'b0, opcode[1:0]};
          endcase
        end
        ST_A_PUSH: push = 1'b1;
        ST_M_PUSH: begin
          memsrc  = 1'b1;
          memRead = 1'b1;
          push    = 1'b1;
          stksrc  = 2'd1;
        end
        ST_M_WRITE: begin
          memWrite = 1'b1;
          memsrc   = 1'b1;
        end
        ST_TOS, ST_DUP_TOS: tos = 1'b1;
        ST_JUMP: begin
          pcsrc = 1'b1;
          ldpc  = 1'b1;
        end
        ST_DUP_PUSH: begin
          push   = 1'b1;
          stksrc = 2'd2;
        end
        ST_HALT:  halted = 1'b1;
        ST_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

  // Occupancy counter; decode-stage checks keep it within 0..DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sp_count <= '0;
    else if (push) sp_count <= sp_count + SP_W'(1);
    else if (pop)  sp_count <= sp_count - SP_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_code <= FC_NONE;
    else     fault_code <= fault_code_nxt;
  end

endmodule

// File: tb/tb_stack_ctrl_unit.sv
// Self-checking bench for stack_ctrl_unit: a per-cycle scoreboard of expected
// strobes, occupancy and fault code, filled when each instruction is issued.
module tb_stack_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [7:0] d_out = 8'd0;
  logic ldpc, ldmem, ldalu, pcsrc, memsrc, alusrcA, alusrcB, memRead, memWrite;
  logic push, pop, tos, halted, fault;
  logic [1:0] stksrc, fault_code;
  logic [2:0] alu_control;
  logic [4:0] sp_count;

  stack_ctrl_unit #(.DATA_W(8), .DEPTH(16), .SP_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .d_out(d_out),
    .ldpc(ldpc), .ldmem(ldmem), .ldalu(ldalu), .pcsrc(pcsrc), .memsrc(memsrc),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .memRead(memRead), .memWrite(memWrite),
    .push(push), .pop(pop), .tos(tos), .stksrc(stksrc), .alu_control(alu_control),
    .sp_count(sp_count), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] B_LDPC   = 19'h40000;
  localparam logic [18:0] B_LDMEM  = 19'h20000;
  localparam logic [18:0] B_LDALU  = 19'h10000;
  localparam logic [18:0] B_PCSRC  = 19'h08000;
  localparam logic [18:0] B_MEMSRC = 19'h04000;
  localparam logic [18:0] B_SRCA   = 19'h02000;
  localparam logic [18:0] B_SRCB   = 19'h01000;
  localparam logic [18:0] B_MEMRD  = 19'h00800;
  localparam logic [18:0] B_MEMWR  = 19'h00400;
  localparam logic [18:0] B_PUSH   = 19'h00200;
  localparam logic [18:0] B_POP    = 19'h00100;
  localparam logic [18:0] B_TOS    = 19'h00080;
  localparam logic [18:0] B_STK1   = 19'h00020;
  localparam logic [18:0] B_STK2   = 19'h00040;
  localparam logic [18:0] B_HALT   = 19'h00002;
  localparam logic [18:0] B_FAULT  = 19'h00001;

  localparam logic [18:0] E_IF     = B_LDPC | B_LDMEM | B_MEMRD;
  localparam logic [18:0] E_NONE   = 19'h0;
  localparam logic [18:0] E_MPUSH  = B_MEMSRC | B_MEMRD | B_PUSH | B_STK1;
  localparam logic [18:0] E_MWR    = B_MEMWR | B_MEMSRC;
  localparam logic [18:0] E_JUMP   = B_PCSRC | B_LDPC;
  localparam logic [18:0] E_DPUSH  = B_PUSH | B_STK2;

  typedef struct {
    logic [18:0] vec;
    logic [4:0]  sp;
    logic [1:0]  fc;
  } exp_t;

  exp_t       q[$];
  logic [4:0] m_sp = 5'd0;
  logic [1:0] m_fc = 2'd0;
  int         checks = 0;
  int         failures = 0;

  function automatic logic [18:0] dut_vec();
    return {ldpc, ldmem, ldalu, pcsrc, memsrc, alusrcA, alusrcB, memRead, memWrite,
            push, pop, tos, stksrc, alu_control, halted, fault};
  endfunction

  function automatic logic [18:0] e_alu(input logic [2:0] ac);
    return B_LDALU | B_SRCA | B_SRCB | (19'(ac) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_e(input logic [18:0] v);
    q.push_back('{vec: v, sp: m_sp, fc: m_fc});
    if ((v & B_PUSH) != 0) m_sp = m_sp + 5'd1;
    if ((v & B_POP) != 0)  m_sp = m_sp - 5'd1;
  endtask

  // Expected per-cycle behaviour of one instruction, derived from its opcode
  task automatic issue(input logic [3:0] op, input logic [7:0] d);
    int need;
    bit bin;
    opcode = op;
    d_out  = d;
    push_e(E_IF);
    push_e(E_NONE);
    bin  = (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd8) || (op == 4'd9);
    need = bin ? 2 : ((op == 4'd3) || (op == 4'd5) || (op == 4'd7) ||
                      (op == 4'd10) || (op == 4'd11)) ? 1 : 0;
    if (op >= 4'd14 || int'(m_sp) < need ||
        ((op == 4'd4 || op == 4'd10) && m_sp == 5'd16)) begin
      if (op >= 4'd14)         m_fc = 2'd3;
      else if (int'(m_sp) < need) m_fc = 2'd1;
      else                     m_fc = 2'd2;
      repeat (20) push_e(B_FAULT);
    end else begin
      case (op)
        4'd0, 4'd1, 4'd2, 4'd8, 4'd9: begin
          push_e(B_POP);
          push_e(B_POP);
          push_e(e_alu(op == 4'd8 ? 3'd4 : op == 4'd9 ? 3'd5 : op[2:0]));
          push_e(B_PUSH);
        end
        4'd3: begin push_e(B_POP); push_e(e_alu(3'd3)); push_e(B_PUSH); end
        4'd4: push_e(E_MPUSH);
        4'd5: begin push_e(B_POP); push_e(E_MWR); end
        4'd6: push_e(E_JUMP);
        4'd7: begin push_e(B_TOS); push_e(E_NONE); if (d == 8'd0) push_e(E_JUMP); end
        4'd11: begin push_e(B_TOS); push_e(E_NONE); if (d != 8'd0) push_e(E_JUMP); end
        4'd10: begin push_e(B_TOS); push_e(E_DPUSH); end
        4'd13: repeat (30) push_e(B_HALT);
        default: ;
      endcase
    end
  endtask

  // Compare up to n queued cycles (n<0: all), one per clock at mid-low phase
  task automatic drain(input int n);
    exp_t e;
    int   cnt = 0;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      e = q.pop_front();
      #1;
      chk("strobes", 32'(dut_vec()), 32'(e.vec));
      chk("sp_count", 32'(sp_count), 32'(e.sp));
      chk("fault_code", 32'(fault_code), 32'(e.fc));
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_strobes", 32'(dut_vec()), 32'(0));
    chk("rst_sp", 32'(sp_count), 32'(0));
    chk("rst_fc", 32'(fault_code), 32'(0));
    @(negedge clk);
    chk("rst_hold_strobes", 32'(dut_vec()), 32'(0));
    rst  = 1'b0;
    q.delete();
    m_sp = 5'd0;
    m_fc = 2'd0;
  endtask

  task automatic run(input logic [3:0] op, input logic [7:0] d);
    issue(op, d);
    drain(-1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // Abandon an ADD while it is in S_POP2
    run(4'd4, 8'd0);
    run(4'd4, 8'd0);
    issue(4'd0, 8'd0);
    drain(3);
    do_reset();
    // Arithmetic, memory, DUP and control flow
    run(4'd4, 8'd0); run(4'd4, 8'd0); run(4'd0, 8'd0);
    run(4'd4, 8'd0); run(4'd9, 8'd0);
    run(4'd4, 8'd0); run(4'd1, 8'd0);
    run(4'd4, 8'd0); run(4'd8, 8'd0);
    run(4'd4, 8'd0); run(4'd2, 8'd0);
    run(4'd3, 8'd0); run(4'd10, 8'd0); run(4'd5, 8'd0);
    run(4'd6, 8'd0); run(4'd12, 8'd0);
    run(4'd7, 8'd0); run(4'd7, 8'd1);
    run(4'd11, 8'd0); run(4'd11, 8'h80);
    run(4'd5, 8'd0);
    run(4'd4, 8'd0);
    // Underflow: ADD with one entry
    run(4'd0, 8'd0);
    do_reset();
    // Overflow: 17th PUSH
    repeat (16) run(4'd4, 8'd0);
    run(4'd4, 8'd0);
    do_reset();
    // DUP fills the last slot, then overflows
    repeat (15) run(4'd4, 8'd0);
    run(4'd10, 8'd0);
    run(4'd10, 8'd0);
    do_reset();
    // POP on empty stack
    run(4'd5, 8'd0);
    do_reset();
    run(4'hE, 8'd0);
    do_reset();
    run(4'd13, 8'd0);
    do_reset();
    run(4'd12, 8'd0);
    issue(4'd12, 8'd0);
    drain(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_ctrl_unit.md
# stack_ctrl_unit

Parametrised multi-cycle control unit for the stack-machine datapath. It sequences fetch, decode, stack pop/push, ALU, memory and branch micro-steps from a 4-bit opcode. It tracks stack occupancy and traps underflow, overflow and illegal opcodes in a sticky fault state. It sits between the instruction register and the PC, memory, ALU and stack datapath strobes.

## Interface
- DATA_W, 8, width of top-of-stack data used by the branch zero test
- DEPTH, 16, stack capacity in entries
- SP_W, 5, occupancy counter width; must satisfy 2^SP_W > DEPTH
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- opcode  in  4  instruction opcode, sampled in ID and held stable by the datapath for the whole instruction
- d_out  in  DATA_W  top-of-stack value, valid in Z_CHECK
- ldpc, ldmem, ldalu, pcsrc, memsrc, alusrcA, alusrcB, memRead, memWrite, push, pop, tos  out  1 each  datapath strobes
- stksrc  out  2  push source: 0 ALU, 1 memory, 2 TOS register
- alu_control  out  3  0 ADD, 1 SUB, 2 AND, 3 NOT, 4 OR, 5 XOR
- sp_count  out  SP_W  current stack occupancy
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- fault_code  out  2  0 none, 1 underflow, 2 overflow, 3 illegal; held until reset

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 PUSH, 5 POP, 6 JMP, 7 JZ
  - 8 OR, 9 XOR, 10 DUP, 11 JNZ, 12 NOP, 13 HALT
  - 14 and 15 are illegal.
- States: IF, ID, S_POP1, S_POP2, ALU, A_PUSH, M_PUSH, M_POP, M_WRITE, TOS, Z_CHECK, JUMP, DUP_TOS, DUP_PUSH, HALT, FAULT (4-bit encoding).
- IF: ldpc, memRead, ldmem asserted; alu_control=ADD; all other strobes 0. Next state is ID.
- ID, no strobes; next state by opcode:
  - binary ops (0,1,2,8,9) → S_POP1
  - NOT → S_POP2
  - PUSH → M_PUSH
  - POP → M_POP
  - JMP → JUMP
  - JZ/JNZ → TOS
  - DUP → DUP_TOS
  - NOP → IF
  - HALT → HALT
- ID checks run in priority order:
  1. Illegal opcode → FAULT, code 3.
  2. Underflow → FAULT, code 1, when sp_count is below the requirement: binary ops need ≥2; NOT, POP, JZ, JNZ and DUP need ≥1.
  3. Overflow → FAULT, code 2, when sp_count==DEPTH for PUSH or DUP.
- S_POP1 and S_POP2: pop=1. S_POP1 → S_POP2 → ALU.
- ALU: alusrcA=alusrcB=ldalu=1. alu_control is 0–3 for opcodes 0–3, 4 for OR, 5 for XOR. Next state is A_PUSH.
- A_PUSH: push=1, stksrc=0. Next state is IF.
- M_PUSH: memsrc=1, memRead=1, push=1, stksrc=1. Next state is IF.
- M_POP: pop=1. Next state is M_WRITE.
- M_WRITE: memWrite=1, memsrc=1. Next state is IF.
- TOS: tos=1. Next state is Z_CHECK.
- Z_CHECK, no strobes. Next state is JUMP if (JZ and d_out==0) or (JNZ and d_out!=0); otherwise IF. The stack is not popped.
- JUMP: pcsrc=1, ldpc=1. Next state is IF.
- DUP_TOS: tos=1. Next state is DUP_PUSH.
- DUP_PUSH: push=1, stksrc=2. Next state is IF.
- HALT: halted=1, all strobes 0. Stays in HALT until reset.
- FAULT: fault=1, all strobes 0. Stays in FAULT until reset.
- sp_count: +1 on a clock edge with push=1, −1 with pop=1; push and pop are never asserted together. Width is SP_W and it never wraps; the ID checks guarantee 0 ≤ sp_count ≤ DEPTH.

## Timing
- Moore outputs are decoded combinationally from the registered state. All strobes are forced to 0 while rst=1.
- Reset values: state=IF, sp_count=0, fault_code=0, fault=0, halted=0. Reset mid-instruction abandons it immediately; the first IF follows rst deassertion.
- Cycles per instruction, including IF and ID:
  - binary op 6; NOT 5
  - PUSH 3; POP 4
  - JMP 3
  - JZ/JNZ 5 taken, 4 not taken
  - DUP 4; NOP 2
- The fault decision is made in ID; no strobe of the faulting instruction is issued, and sp_count is unchanged.
- d_out is sampled only in Z_CHECK.

## Test plan
- Reset mid-ADD (assert rst in S_POP2) → state=IF, sp_count=0, no strobes during rst; the next fetch is clean.
- PUSH, PUSH, ADD → sp_count sequence 1, 2, 1, 0 (pops), 1. ADD takes 6 cycles with alu_control=0 in ALU; XOR gives alu_control=5.
- ADD with sp_count=1 → FAULT at the ID+1 edge, fault_code=1, no pop strobe; the state stays in FAULT for 20 cycles.
- DEPTH=16: 16 PUSHes, then a 17th PUSH → FAULT, code 2, sp_count=16. DUP at 15 entries → sp_count=16, stksrc=2 in DUP_PUSH.
- JZ with d_out=0 → JUMP, ldpc=pcsrc=1, 5 cycles. JZ with d_out=8'h01 → IF after 4 cycles. JNZ gives the inverse. sp_count is unchanged in all cases.
- Opcode 4'hE → FAULT, code 3. HALT → halted=1 and ldpc=0 indefinitely until rst.
